// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM states,
// default frame marker and instruction word width.
package imem_loader_pkg;

  localparam logic [7:0]  DefaultSyncByte = 8'hA5;
  localparam int unsigned InstrWidth      = 16;

  typedef enum logic [3:0] {
    StIdle,
    StCntHi,
    StCntLo,
    StDataHi,
    StDataLo,
    StWrite,
    StCheck,
    StFinish,
    StDone,
    StError
  } state_e;

endpackage

// File: rtl/loader_word_assembler.sv
// Assembles big-endian instruction words from two byte loads and, when
// IMEM_LOADER_CHECKSUM_EN is defined, keeps the running XOR of frame bytes.
module loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_hi,
  input  logic                  load_lo,
  input  logic [7:0]            data,
`ifdef IMEM_LOADER_CHECKSUM_EN
  input  logic                  sum_clear,
  input  logic                  sum_en,
  output logic [7:0]            sum,
`endif
  output logic [InstrWidth-1:0] word
);

  logic [7:0] hi_q;
  logic [7:0] lo_q;

  // Byte holding registers; the word stays stable until the next byte load.
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (load_hi) hi_q <= data;
      if (load_lo) lo_q <= data;
    end
  end

  assign word = {hi_q, lo_q};

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;

  // Running XOR over every byte after the sync marker; restarts on sync.
  always_ff @(posedge clock) begin
    if (reset || sum_clear) begin
      sum_q <= '0;
    end else if (sum_en) begin
      sum_q <= sum_q ^ data;
    end
  end

  assign sum = sum_q;
`endif

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: accepts a framed byte stream (SYNC, COUNT_HI,
// COUNT_LO, COUNT big-endian words) and writes words from address 0 while
// holding the CPU in reset. Build macro IMEM_LOADER_CHECKSUM_EN appends a
// trailing XOR checksum byte that must match before the image is released.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [7:0]  SYNC_BYTE  = DefaultSyncByte
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [InstrWidth-1:0] mem_data,
  output logic                  mem_wren,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e StAfterLast = StCheck;
`else
  localparam state_e StAfterLast = StFinish;
`endif

  localparam logic [31:0] Capacity = 32'd1 << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic                  hold_q, hold_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  accept;
  logic                  is_sync;
  logic [15:0]           count_full;
  logic [ADDR_WIDTH:0]   words_inc;

  assign rx_ready   = (state_q != StWrite) && (state_q != StFinish);
  assign accept     = rx_valid && rx_ready;
  assign is_sync    = rx_data == SYNC_BYTE;
  assign count_full = {count_q[15:8], rx_data};
  assign words_inc  = words_q + (ADDR_WIDTH + 1)'(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic       sum_clear;
  logic       sum_en;
  logic [7:0] sum;

  assign sum_clear = accept && is_sync && (state_q inside {StIdle, StDone, StError});
  assign sum_en    = accept && (state_q inside {StCntHi, StCntLo, StDataHi, StDataLo});
`endif

  loader_word_assembler u_assembler (
    .clock     (clock),
    .reset     (reset),
    .load_hi   (accept && (state_q == StDataHi)),
    .load_lo   (accept && (state_q == StDataLo)),
    .data      (rx_data),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .sum_clear (sum_clear),
    .sum_en    (sum_en),
    .sum       (sum),
`endif
    .word      (mem_data)
  );

  // Next-state and datapath updates; flags change only on state transitions.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    words_d = words_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    case (state_q)
      StIdle, StDone, StError: begin
        // A new frame re-asserts the CPU hold before anything is overwritten.
        if (accept && is_sync) begin
          state_d = StCntHi;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          hold_d  = 1'b1;
        end
      end
      StCntHi: begin
        if (accept) begin
          count_d[15:8] = rx_data;
          state_d       = StCntLo;
        end
      end
      StCntLo: begin
        if (accept) begin
          count_d[7:0] = rx_data;
          addr_d       = '0;
          words_d      = '0;
          if (32'(count_full) > Capacity) begin
            state_d = StError;
            error_d = 1'b1;
            busy_d  = 1'b0;
            hold_d  = 1'b1;
          end else if (count_full == 16'd0) begin
            state_d = StAfterLast;
          end else begin
            state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        if (accept) state_d = StDataLo;
      end
      StDataLo: begin
        if (accept) state_d = StWrite;
      end
      StWrite: begin
        addr_d  = addr_q + 1'b1;
        words_d = words_inc;
        state_d = (32'(words_inc) == 32'(count_q)) ? StAfterLast : StDataHi;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        if (accept) begin
          if (rx_data == sum) begin
            state_d = StFinish;
          end else begin
            state_d = StError;
            error_d = 1'b1;
            busy_d  = 1'b0;
            hold_d  = 1'b1;
          end
        end
      end
`endif
      StFinish: begin
        state_d = StDone;
        done_d  = 1'b1;
        error_d = 1'b0;
        busy_d  = 1'b0;
        hold_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      addr_q  <= '0;
      words_q <= '0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign mem_wren     = state_q == StWrite;
  assign mem_address  = addr_q;
  assign cpu_hold     = hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule
